// File: rtl/alu_issue_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_issue_pkg / alu_arb_if
// Purpose : shared ALU control word type and the bundle of requester, response
//           and ALU-side signals around alu_issue_arbiter.
// Modports: master - requesters plus ALU core (drive req_*, resp_ready,
//                    alu_result; observe grants, responses and ALU launch)
//           slave  - the arbiter itself (the mirror image)
// -----------------------------------------------------------------------------
package alu_issue_pkg;

  typedef enum logic [3:0] {
    CORE_OP_ADD     = 4'h0,
    CORE_OP_SUB     = 4'h1,
    CORE_OP_AND     = 4'h2,
    CORE_OP_OR      = 4'h3,
    CORE_OP_XOR     = 4'h4,
    CORE_OP_SLL     = 4'h5,
    CORE_OP_SRL     = 4'h6,
    CORE_OP_SLT     = 4'h7,
    CORE_OP_INVALID = 4'hF
  } core_op_e;

  typedef struct packed {
    core_op_e op;
    logic     cmp_unsigned;
  } s_control;

endpackage

interface alu_arb_if #(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32
) ();

  logic [N_REQ-1:0]                   req_valid;
  logic [N_REQ-1:0]                   req_ready;
  alu_issue_pkg::s_control [N_REQ-1:0] req_ctrl;
  logic [N_REQ-1:0][XLEN-1:0]         req_a;
  logic [N_REQ-1:0][XLEN-1:0]         req_b;

  logic [N_REQ-1:0]                   resp_valid;
  logic [N_REQ-1:0]                   resp_ready;
  logic [N_REQ-1:0][XLEN-1:0]         resp_data;
  logic [N_REQ-1:0]                   resp_err;

  logic                               alu_valid;
  alu_issue_pkg::s_control            alu_ctrl;
  logic [XLEN-1:0]                    alu_a;
  logic [XLEN-1:0]                    alu_b;
  logic [XLEN-1:0]                    alu_result;

  modport master (
    output req_valid, req_ctrl, req_a, req_b, resp_ready, alu_result,
    input  req_ready, resp_valid, resp_data, resp_err,
           alu_valid, alu_ctrl, alu_a, alu_b
  );

  modport slave (
    input  req_valid, req_ctrl, req_a, req_b, resp_ready, alu_result,
    output req_ready, resp_valid, resp_data, resp_err,
           alu_valid, alu_ctrl, alu_a, alu_b
  );

endinterface

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
// Purpose : shares one fixed-latency ALU between N_REQ issue requesters.
//           One grant per cycle; a tag pipeline of LATENCY stages routes each
//           result (or an invalid-op error) back to a per-requester hold
//           register that is held until the requester consumes it.
// Ports   : clk   - rising-edge clock
//           rst_n - synchronous active-low reset
//           bus   - alu_arb_if.slave (requests, responses, ALU launch/result)
// Options : ALU_ARB_RR_EN defined   -> round-robin grant (pointer register)
//           ALU_ARB_RR_EN undefined -> fixed priority, lowest index wins
// -----------------------------------------------------------------------------
module alu_issue_arbiter
  import alu_issue_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int XLEN    = 32,
  parameter int LATENCY = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_arb_if.slave bus
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]             pending_q, pending_d;
  logic [LATENCY-1:0]           tag_v_q, tag_v_d;
  logic [LATENCY-1:0][IDW-1:0]  tag_id_q, tag_id_d;
  logic [LATENCY-1:0]           tag_err_q, tag_err_d;
  logic [N_REQ-1:0]             resp_valid_q, resp_valid_d;
  logic [N_REQ-1:0]             resp_err_q, resp_err_d;
  logic [N_REQ-1:0][XLEN-1:0]   resp_data_q, resp_data_d;

  logic [N_REQ-1:0]             eligible;
  logic                         gnt;
  logic [IDW-1:0]               gnt_id;
  logic                         gnt_err;
  logic [IDW-1:0]               exit_id;

`ifdef ALU_ARB_RR_EN
  logic [IDW-1:0]               rr_ptr_q, rr_ptr_d;
  int                           idx;
`endif

  // Grant selection and ALU launch
  always_comb begin
    eligible = bus.req_valid & ~pending_q;
    gnt      = 1'b0;
    gnt_id   = '0;
`ifdef ALU_ARB_RR_EN
    idx      = 0;
    // Search starts one past the last winner and wraps.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!gnt && eligible[idx]) begin
        gnt    = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
`else
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        gnt    = 1'b1;
        gnt_id = IDW'(i);
      end
    end
`endif
    // No grants while reset is held, so nothing is launched or accepted.
    if (!rst_n) gnt = 1'b0;

    gnt_err = gnt && (bus.req_ctrl[gnt_id].op == CORE_OP_INVALID);

    bus.req_ready = '0;
    if (gnt) bus.req_ready[gnt_id] = 1'b1;

    bus.alu_valid = gnt & ~gnt_err;
    bus.alu_ctrl  = bus.req_ctrl[gnt_id];
    bus.alu_a     = bus.req_a[gnt_id];
    bus.alu_b     = bus.req_b[gnt_id];
  end

  // Tag pipeline, response hold registers, pending bits
  always_comb begin
    tag_v_d[0]   = gnt;
    tag_id_d[0]  = gnt_id;
    tag_err_d[0] = gnt_err;
    for (int s = 1; s < LATENCY; s++) begin
      tag_v_d[s]   = tag_v_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
      tag_err_d[s] = tag_err_q[s-1];
    end

    exit_id      = tag_id_q[LATENCY-1];
    resp_valid_d = resp_valid_q & ~bus.resp_ready;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    // The exiting id cannot be holding an unconsumed result: pending
    // blocked its re-grant until the previous handshake.
    if (tag_v_q[LATENCY-1]) begin
      resp_valid_d[exit_id] = 1'b1;
      resp_err_d[exit_id]   = tag_err_q[LATENCY-1];
      resp_data_d[exit_id]  = tag_err_q[LATENCY-1] ? '0 : bus.alu_result;
    end

    pending_d = pending_q & ~(resp_valid_q & bus.resp_ready);
    if (gnt) pending_d[gnt_id] = 1'b1;

`ifdef ALU_ARB_RR_EN
    rr_ptr_d = gnt ? gnt_id : rr_ptr_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q    <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      tag_err_q    <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      resp_data_q  <= '0;
`ifdef ALU_ARB_RR_EN
      rr_ptr_q     <= IDW'(N_REQ - 1);
`endif
    end else begin
      pending_q    <= pending_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      tag_err_q    <= tag_err_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
`ifdef ALU_ARB_RR_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_arbiter
// Directed bench: dut_a (N_REQ=2, LATENCY=1) and dut_b (N_REQ=3, LATENCY=3),
// each fed by a small behavioural ALU with the matching latency.
// -----------------------------------------------------------------------------
module tb_alu_issue_arbiter;
  import alu_issue_pkg::*;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_chk;
  int   n_pass;

  alu_arb_if #(.N_REQ(2), .XLEN(32)) ifa ();
  alu_arb_if #(.N_REQ(3), .XLEN(32)) ifb ();

  alu_issue_arbiter #(.N_REQ(2), .XLEN(32), .LATENCY(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (ifa)
  );

  alu_issue_arbiter #(.N_REQ(3), .XLEN(32), .LATENCY(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input s_control c, input logic [31:0] a,
                                        input logic [31:0] b);
    case (c.op)
      CORE_OP_ADD: return a + b;
      CORE_OP_SUB: return a - b;
      CORE_OP_AND: return a & b;
      CORE_OP_OR:  return a | b;
      CORE_OP_XOR: return a ^ b;
      default:     return 32'hBAD0_C0DE;
    endcase
  endfunction

  // ALU models: result appears exactly LATENCY cycles after alu_valid.
  logic [31:0] res_a;
  logic [31:0] pb0, pb1, pb2;

  always @(posedge clk) begin
    res_a <= ifa.alu_valid ? alu_f(ifa.alu_ctrl, ifa.alu_a, ifa.alu_b) : 32'hBAD0_C0DE;
    pb0   <= ifb.alu_valid ? alu_f(ifb.alu_ctrl, ifb.alu_a, ifb.alu_b) : 32'hBAD0_C0DE;
    pb1   <= pb0;
    pb2   <= pb1;
  end

  assign ifa.alu_result = res_a;
  assign ifb.alu_result = pb2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] cont_exp [6];
  logic [1:0] tie_exp;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    ifa.req_valid  = '0; ifa.req_ctrl = '0; ifa.req_a = '0; ifa.req_b = '0;
    ifa.resp_ready = '0;
    ifb.req_valid  = '0; ifb.req_ctrl = '0; ifb.req_a = '0; ifb.req_b = '0;
    ifb.resp_ready = '0;
    cont_exp = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
`ifdef ALU_ARB_RR_EN
    tie_exp = 2'b10;
`else
    tie_exp = 2'b01;
`endif

    // ---- reset state, requests present during reset
    ifa.req_valid = 2'b11;
    ifa.req_ctrl[0].op = CORE_OP_ADD;
    ifa.req_ctrl[1].op = CORE_OP_ADD;
    cyc(); cyc(); #1;
    chk("rst_req_ready", 64'(ifa.req_ready), 64'h0);
    chk("rst_alu_valid", 64'(ifa.alu_valid), 64'h0);
    chk("rst_resp_valid", 64'(ifa.resp_valid), 64'h0);
    chk("rst_resp_err", 64'(ifa.resp_err), 64'h0);
    chk("rst_resp_data0", 64'(ifa.resp_data[0]), 64'h0);
    chk("rst_resp_data1", 64'(ifa.resp_data[1]), 64'h0);
    ifa.req_valid = '0;
    rst_a = 1'b1;

    // ---- single op: 5 + 7
    cyc();
    ifa.req_valid = 2'b01; ifa.req_ctrl[0].op = CORE_OP_ADD;
    ifa.req_a[0] = 32'd5; ifa.req_b[0] = 32'd7; ifa.resp_ready = 2'b00;
    #1;
    chk("add_req_ready", 64'(ifa.req_ready), 64'h1);
    chk("add_alu_valid", 64'(ifa.alu_valid), 64'h1);
    chk("add_alu_a", 64'(ifa.alu_a), 64'd5);
    chk("add_alu_b", 64'(ifa.alu_b), 64'd7);
    chk("add_alu_op", 64'(ifa.alu_ctrl.op), 64'(CORE_OP_ADD));
    cyc(); ifa.req_valid = 2'b00; #1;
    chk("add_t1_resp_valid", 64'(ifa.resp_valid), 64'h0);
    cyc(); #1;
    chk("add_t2_resp_valid", 64'(ifa.resp_valid), 64'h1);
    chk("add_t2_data", 64'(ifa.resp_data[0]), 64'd12);
    chk("add_t2_err", 64'(ifa.resp_err), 64'h0);
    ifa.req_valid = 2'b01; ifa.req_ctrl[0].op = CORE_OP_SUB;
    ifa.req_a[0] = 32'd20; ifa.req_b[0] = 32'd3; ifa.resp_ready = 2'b01;
    #1;
    chk("pend_block_ready", 64'(ifa.req_ready), 64'h0);
    cyc(); #1;
    chk("sub_req_ready", 64'(ifa.req_ready), 64'h1);
    chk("sub_alu_valid", 64'(ifa.alu_valid), 64'h1);
    chk("sub_alu_a", 64'(ifa.alu_a), 64'd20);
    cyc(); ifa.req_valid = 2'b00; #1;
    chk("sub_t1_resp_valid", 64'(ifa.resp_valid), 64'h0);
    cyc(); #1;
    chk("sub_t2_resp_valid", 64'(ifa.resp_valid), 64'h1);
    chk("sub_t2_data", 64'(ifa.resp_data[0]), 64'd17);
    cyc(); #1;
    chk("sub_t3_resp_valid", 64'(ifa.resp_valid), 64'h0);

    // ---- invalid op on req1
    cyc();
    ifa.req_valid = 2'b10; ifa.req_ctrl[1].op = CORE_OP_INVALID;
    ifa.req_a[1] = 32'd9; ifa.req_b[1] = 32'd9; ifa.resp_ready = 2'b11;
    #1;
    chk("inv_req_ready", 64'(ifa.req_ready), 64'h2);
    chk("inv_alu_valid", 64'(ifa.alu_valid), 64'h0);
    cyc(); ifa.req_valid = 2'b00; #1;
    chk("inv_t1_resp_valid", 64'(ifa.resp_valid), 64'h0);
    cyc(); #1;
    chk("inv_t2_resp_valid", 64'(ifa.resp_valid), 64'h2);
    chk("inv_t2_err", 64'(ifa.resp_err), 64'h2);
    chk("inv_t2_data", 64'(ifa.resp_data[1]), 64'h0);
    cyc(); #1;
    chk("inv_t3_resp_valid", 64'(ifa.resp_valid), 64'h0);

    // ---- backpressure on req1
    cyc();
    ifa.req_valid = 2'b10; ifa.req_ctrl[1].op = CORE_OP_OR;
    ifa.req_a[1] = 32'hDEAD_BEEF; ifa.req_b[1] = 32'h0; ifa.resp_ready = 2'b00;
    #1;
    chk("bp_req_ready", 64'(ifa.req_ready), 64'h2);
    chk("bp_alu_valid", 64'(ifa.alu_valid), 64'h1);
    cyc(); ifa.req_valid = 2'b00; #1;
    cyc();
    ifa.req_valid = 2'b10; ifa.req_ctrl[1].op = CORE_OP_ADD;
    ifa.req_a[1] = 32'd1; ifa.req_b[1] = 32'd1;
    #1;
    chk("bp_resp_valid", 64'(ifa.resp_valid), 64'h2);
    chk("bp_data", 64'(ifa.resp_data[1]), 64'hDEAD_BEEF);
    chk("bp_err", 64'(ifa.resp_err), 64'h0);
    chk("bp_ready_blocked", 64'(ifa.req_ready), 64'h0);
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      chk("bp_hold_data", 64'(ifa.resp_data[1]), 64'hDEAD_BEEF);
      chk("bp_hold_valid", 64'(ifa.resp_valid), 64'h2);
      chk("bp_hold_ready", 64'(ifa.req_ready), 64'h0);
    end
    cyc(); ifa.resp_ready = 2'b10; #1;
    chk("bp_rel_ready", 64'(ifa.req_ready), 64'h0);
    chk("bp_rel_valid", 64'(ifa.resp_valid), 64'h2);
    cyc(); ifa.resp_ready = 2'b00; #1;
    chk("bp_regrant_ready", 64'(ifa.req_ready), 64'h2);
    chk("bp_regrant_alu", 64'(ifa.alu_valid), 64'h1);
    chk("bp_regrant_rvalid", 64'(ifa.resp_valid), 64'h0);
    cyc(); ifa.req_valid = 2'b00; #1;
    cyc(); #1;
    chk("bp_new_valid", 64'(ifa.resp_valid), 64'h2);
    chk("bp_new_data", 64'(ifa.resp_data[1]), 64'd2);
    ifa.resp_ready = 2'b11;
    cyc(); #1;
    chk("bp_done_valid", 64'(ifa.resp_valid), 64'h0);

    // ---- contention from reset
    cyc(); rst_a = 1'b0;
    cyc(); rst_a = 1'b1;
    cyc();
    ifa.req_valid = 2'b11;
    ifa.req_ctrl[0].op = CORE_OP_ADD; ifa.req_ctrl[1].op = CORE_OP_ADD;
    ifa.resp_ready = 2'b11;
    #1;
    chk("cont_0", 64'(ifa.req_ready), 64'(cont_exp[0]));
    for (int k = 1; k < 6; k++) begin
      cyc(); #1;
      chk($sformatf("cont_%0d", k), 64'(ifa.req_ready), 64'(cont_exp[k]));
    end
    cyc(); ifa.req_valid = 2'b00;
    repeat (3) cyc();

    // ---- tie after req0 won alone (pointer at 0)
    cyc(); rst_a = 1'b0;
    cyc(); rst_a = 1'b1;
    cyc(); ifa.req_valid = 2'b01; #1;
    chk("tie_first", 64'(ifa.req_ready), 64'h1);
    cyc(); ifa.req_valid = 2'b00;
    cyc();
    cyc(); ifa.req_valid = 2'b11; #1;
    chk("tie_policy", 64'(ifa.req_ready), 64'(tie_exp));
    cyc(); ifa.req_valid = 2'b00;
    repeat (3) cyc();

    // ---- reset one cycle after grant
    cyc();
    ifa.req_valid = 2'b01; ifa.req_ctrl[0].op = CORE_OP_ADD;
    ifa.req_a[0] = 32'd3; ifa.req_b[0] = 32'd3; ifa.resp_ready = 2'b11;
    #1;
    chk("mrst_grant", 64'(ifa.req_ready), 64'h1);
    cyc(); ifa.req_valid = 2'b00; rst_a = 1'b0; #1;
    chk("mrst_ready_in_rst", 64'(ifa.req_ready), 64'h0);
    cyc(); rst_a = 1'b1; #1;
    chk("mrst_resp_valid", 64'(ifa.resp_valid), 64'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("mrst_no_resp", 64'(ifa.resp_valid), 64'h0);
    end
    cyc();
    ifa.req_valid = 2'b11; ifa.req_ctrl[1].op = CORE_OP_ADD;
    ifa.req_a[0] = 32'd4; ifa.req_b[0] = 32'd4;
    #1;
    chk("mrst_pending_clear", 64'(ifa.req_ready), 64'h1);
    cyc(); ifa.req_valid = 2'b00;
    cyc(); #1;
    chk("mrst_post_valid", 64'(ifa.resp_valid), 64'h1);
    chk("mrst_post_data", 64'(ifa.resp_data[0]), 64'd8);
    cyc();

    // ---- LATENCY=3, three requesters back to back
    rst_b = 1'b1;
    cyc();
    ifb.req_valid = 3'b111;
    ifb.req_ctrl[0].op = CORE_OP_ADD; ifb.req_a[0] = 32'd1;   ifb.req_b[0] = 32'd2;
    ifb.req_ctrl[1].op = CORE_OP_SUB; ifb.req_a[1] = 32'd10;  ifb.req_b[1] = 32'd4;
    ifb.req_ctrl[2].op = CORE_OP_XOR; ifb.req_a[2] = 32'hFF;  ifb.req_b[2] = 32'h0F;
    ifb.resp_ready = 3'b111;
    #1;
    chk("l3_g0_ready", 64'(ifb.req_ready), 64'h1);
    chk("l3_g0_alu_valid", 64'(ifb.alu_valid), 64'h1);
    chk("l3_g0_alu_a", 64'(ifb.alu_a), 64'd1);
    cyc(); #1;
    chk("l3_g1_ready", 64'(ifb.req_ready), 64'h2);
    chk("l3_g1_alu_a", 64'(ifb.alu_a), 64'd10);
    cyc(); #1;
    chk("l3_g2_ready", 64'(ifb.req_ready), 64'h4);
    chk("l3_g2_alu_a", 64'(ifb.alu_a), 64'hFF);
    cyc(); ifb.req_valid = 3'b000; #1;
    chk("l3_t3_valid", 64'(ifb.resp_valid), 64'h0);
    cyc(); #1;
    chk("l3_t4_valid", 64'(ifb.resp_valid), 64'h1);
    chk("l3_t4_data", 64'(ifb.resp_data[0]), 64'd3);
    cyc(); #1;
    chk("l3_t5_valid", 64'(ifb.resp_valid), 64'h2);
    chk("l3_t5_data", 64'(ifb.resp_data[1]), 64'd6);
    cyc(); #1;
    chk("l3_t6_valid", 64'(ifb.resp_valid), 64'h4);
    chk("l3_t6_data", 64'(ifb.resp_data[2]), 64'hF0);
    cyc(); #1;
    chk("l3_t7_valid", 64'(ifb.resp_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single ALU core between N_REQ issue requesters (e.g. integer pipes, address-generation, branch-compare) with per-requester valid/ready handshakes. Each cycle, at most one request is granted and its decoded `s_control` word and operands are presented to the ALU. The result is routed back to its requester after the ALU's fixed latency. Invalid control words are caught and answered with an error response without launching the ALU.

## Interface
- `N_REQ`, 2: number of requesters; 2..8.
- `XLEN`, 32: operand/result width.
- `LATENCY`, 1: ALU cycles from `alu_valid` to `alu_result`; ≥1.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `req_valid` in N_REQ: requester i has an operation.
- `req_ready` out N_REQ: requester i accepted this cycle (one-hot or zero).
- `req_ctrl` in N_REQ × `s_control`: decoded ALU control per requester.
- `req_a`, `req_b` in N_REQ × XLEN: operands.
- `resp_valid` out N_REQ: result held for requester i.
- `resp_ready` in N_REQ: requester i consumes its result.
- `resp_data` out N_REQ × XLEN: held result.
- `resp_err` out N_REQ: held response is an invalid-op error; `resp_data` = 0.
- `alu_valid` out 1: launch ALU this cycle.
- `alu_ctrl` out `s_control`; `alu_a`, `alu_b` out XLEN: granted request, combinational from the winning inputs.
- `alu_result` in XLEN: valid exactly LATENCY cycles after an `alu_valid` cycle.

## Operation
- Per requester `pending[i]` register: set on accept, cleared on response handshake (`resp_valid[i] & resp_ready[i]`). At most one outstanding op per requester.
- Eligible(i) = `req_valid[i] & ~pending[i]`, using the registered `pending` value. There is no same-cycle bypass.
- Grant: one eligible requester per cycle, chosen by policy (see Configuration). `req_ready[winner]=1`, all others 0.
- On grant with `req_ctrl.op != CORE_OP_INVALID`: `alu_valid=1`, and `alu_ctrl/a/b` = winner's inputs.
- On grant with `CORE_OP_INVALID`: `alu_valid=0`. The slot is consumed and an error tag is launched.
- Tag pipeline, LATENCY stages deep, each stage holding {valid, id[$clog2(N_REQ)], err}. A tag is pushed every grant cycle.
- When a tag exits the pipeline: the hold register for that id is loaded with `alu_result` (or 0 if err), and `resp_err[id]` = err. `resp_valid[id]` asserts the next cycle.
- The hold register is stable while `resp_valid & ~resp_ready`. Overwrite is impossible, because `pending` blocks a new grant.
- When no grant occurs, `alu_valid=0` and `alu_ctrl/a/b` are don't-care. The bench checks them only when `alu_valid=1`.

## Timing
- Accept at cycle T. `alu_valid` is asserted at T. `alu_result` is sampled at T+LATENCY. `resp_valid` is asserted from T+LATENCY+1.
- Invalid op: `resp_valid` with `resp_err` also asserts at T+LATENCY+1, giving uniform latency.
- Throughput: one grant per cycle in aggregate. A single requester gets one op per LATENCY+2 cycles if it consumes immediately.
- Response handshake at cycle C: that requester is eligible again at C+1.
- Reset values (`rst_n=0` at an edge): `pending`=0, tag pipeline invalid, `resp_valid`=0, `resp_err`=0, `resp_data`=0, RR pointer = N_REQ-1.
- Combinational outputs during reset: `req_ready`=0, `alu_valid`=0.
- Reset mid-operation: in-flight tags are discarded. Late `alu_result` values are ignored and no response is produced.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin policy. The search starts at pointer+1 and wraps modulo N_REQ. The pointer updates to the winner only on a grant.
- `ALU_ARB_RR_EN` undefined: fixed priority, lowest index wins. There is no pointer register.

## Test plan
- Single op, LATENCY=1: req0 sends ADD, a=5, b=7 at T → `alu_valid` at T. The ALU model returns 12 at T+1. `resp_valid[0]` with `resp_data`=12 at T+2.
- Contention with RR_EN: req0 and req1 both continuously valid from reset, each with `resp_ready`=1 → grants alternate 0,1,0,1. Without the macro → grant 0, then 1 only while `pending[0]`=1.
- Backpressure: `resp_ready[1]`=0 for 10 cycles after a result of 0xDEADBEEF → `resp_data[1]` stays 0xDEADBEEF, and `req_ready[1]` stays 0 despite `req_valid[1]`. Release → handshake, then `req_ready[1]` can assert the next cycle.
- Invalid op: req1 sends `CORE_OP_INVALID` → `alu_valid`=0 in the grant cycle, then `resp_valid[1]` with `resp_err`=1 and data 0 at T+LATENCY+1.
- LATENCY=3, three requesters granted back-to-back at T, T+1, T+2 → each result is routed to the correct id at T+4, T+5, T+6.
- Reset mid-flight: assert `rst_n`=0 one cycle after a grant → no `resp_valid` ever appears for that op, and all `pending` bits are 0 after reset.
